// File: rtl/rc4_prga.sv
// RC4 pseudo-random generation and decrypt stage.
// Walks the key-scheduled S array in place, XORs the keystream with a
// length-prefixed ciphertext buffer and writes the length-prefixed plaintext.
// Every output is a register. The address or data intended for state X is
// computed while leaving the previous state, so it is already on the pins
// during X. Read data is consumed one cycle after its address is on the pins.
module rc4_prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    IDLE,
    RD_LEN,
    WAIT_LEN,
    WR_LEN,
    NEXT,
    WAIT_SI,
    CALC_J,
    RD_SJ,
    WAIT_SJ,
    WR_I,
    WR_J,
    RD_PAD,
    WAIT_PAD,
    WR_PT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] len_q, len_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] ctb_q, ctb_d;
  logic       rdy_q, rdy_d;
  logic [7:0] s_addr_q, s_addr_d;
  logic [7:0] s_wrdata_q, s_wrdata_d;
  logic       s_wren_q, s_wren_d;
  logic [7:0] ct_addr_q, ct_addr_d;
  logic [7:0] pt_addr_q, pt_addr_d;
  logic [7:0] pt_wrdata_q, pt_wrdata_d;
  logic       pt_wren_q, pt_wren_d;

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign ct_addr   = ct_addr_q;
  assign pt_addr   = pt_addr_q;
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    len_d       = len_q;
    si_d        = si_q;
    sj_d        = sj_q;
    ctb_d       = ctb_q;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    s_wren_d    = 1'b0;
    ct_addr_d   = ct_addr_q;
    pt_addr_d   = pt_addr_q;
    pt_wrdata_d = pt_wrdata_q;
    pt_wren_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          i_d       = '0;
          j_d       = '0;
          k_d       = '0;
          ct_addr_d = '0;
          state_d   = RD_LEN;
        end
      end
      RD_LEN: state_d = WAIT_LEN;
      WAIT_LEN: begin
        len_d       = ct_rddata;
        pt_addr_d   = '0;
        pt_wrdata_d = ct_rddata;
        pt_wren_d   = 1'b1;
        state_d     = WR_LEN;
      end
      WR_LEN: state_d = NEXT;
      NEXT: begin
        // Compare before incrementing so k stops at L without wrapping.
        if (k_q == len_q) begin
          state_d = IDLE;
        end else begin
          k_d      = k_q + 8'd1;
          i_d      = i_q + 8'd1;
          s_addr_d = i_q + 8'd1;
          state_d  = WAIT_SI;
        end
      end
      WAIT_SI: state_d = CALC_J;
      CALC_J: begin
        si_d     = s_rddata;
        j_d      = j_q + s_rddata;
        s_addr_d = j_q + s_rddata;
        state_d  = RD_SJ;
      end
      RD_SJ: state_d = WAIT_SJ;
      WAIT_SJ: begin
        sj_d       = s_rddata;
        s_addr_d   = i_q;
        s_wrdata_d = s_rddata;
        s_wren_d   = 1'b1;
        state_d    = WR_I;
      end
      WR_I: begin
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren_d   = 1'b1;
        ct_addr_d  = k_q;
        state_d    = WR_J;
      end
      WR_J: begin
        // Pad address goes out only after the second swap write has landed.
        s_addr_d = si_q + sj_q;
        state_d  = RD_PAD;
      end
      RD_PAD: begin
        ctb_d   = ct_rddata;
        state_d = WAIT_PAD;
      end
      WAIT_PAD: begin
        pt_addr_d   = k_q;
        pt_wrdata_d = s_rddata ^ ctb_q;
        pt_wren_d   = 1'b1;
        state_d     = WR_PT;
      end
      WR_PT: state_d = NEXT;
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      len_q       <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      ctb_q       <= '0;
      rdy_q       <= 1'b1;
      s_addr_q    <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= '0;
      pt_addr_q   <= '0;
      pt_wrdata_q <= '0;
      pt_wren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      len_q       <= len_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      ctb_q       <= ctb_d;
      rdy_q       <= rdy_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
      ct_addr_q   <= ct_addr_d;
      pt_addr_q   <= pt_addr_d;
      pt_wrdata_q <= pt_wrdata_d;
      pt_wren_q   <= pt_wren_d;
    end
  end

endmodule

// File: tb/tb_rc4_prga.sv
// Testbench for rc4_prga: synchronous-read memory models, an array-based RC4
// reference model, and directed plus randomized runs.
module tb_rc4_prga;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;

  rc4_prga dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rdy      (rdy),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren),
    .ct_addr  (ct_addr),
    .ct_rddata(ct_rddata),
    .pt_addr  (pt_addr),
    .pt_wrdata(pt_wrdata),
    .pt_wren  (pt_wren)
  );

  always #5 clk = ~clk;

  // Memories, preload images and reference model state.
  logic [7:0] s_mem  [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] s_init [256];
  logic [7:0] ct_init[256];
  logic [7:0] ref_s  [256];
  logic [7:0] ref_ct [256];
  logic [7:0] ref_pt [256];
  logic [7:0] key_b  [16];
  logic       load;

  // Synchronous-read memories; writes land at the edge ending a wren cycle.
  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < 256; a++) begin
        s_mem[a]  <= s_init[a];
        ct_mem[a] <= ct_init[a];
        pt_mem[a] <= '0;
      end
    end else begin
      if (s_wren)  s_mem[s_addr]   <= s_wrdata;
      if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
  end

  int n_cmp = 0;
  int n_err = 0;
  int pt_wr_cnt, s_wr_cnt, cur_l;
  bit mon_on = 1'b0;
  logic prev_ptw = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; sample at the falling edge and run the protocol checks.
  task automatic tick();
    @(negedge clk);
    if (mon_on) begin
      chk("wren_exclusive", {31'd0, s_wren & pt_wren}, 32'd0);
      chk("no_write_when_idle", {31'd0, rdy & (s_wren | pt_wren)}, 32'd0);
      chk("pt_wren_single", {31'd0, prev_ptw & pt_wren}, 32'd0);
      if (pt_wren) chk("pt_addr_le_len", {31'd0, (int'(pt_addr) <= cur_l)}, 32'd1);
    end
    if (pt_wren) pt_wr_cnt++;
    if (s_wren)  s_wr_cnt++;
    prev_ptw = pt_wren;
  endtask

  task automatic ksa(input int klen);
    int j;
    for (int x = 0; x < 256; x++) ref_s[x] = 8'(x);
    j = 0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] t;
      j = (j + int'(ref_s[x]) + int'(key_b[x % klen])) % 256;
      t = ref_s[x]; ref_s[x] = ref_s[j]; ref_s[j] = t;
    end
  endtask

  task automatic model_run(input int l);
    int i, j, si, sj;
    i = 0; j = 0;
    ref_pt[0] = ref_ct[0];
    for (int k = 1; k <= l; k++) begin
      i = (i + 1) % 256;
      si = int'(ref_s[i]);
      j = (j + si) % 256;
      sj = int'(ref_s[j]);
      ref_s[i] = 8'(sj);
      ref_s[j] = 8'(si);
      ref_pt[k] = ref_s[(si + sj) % 256] ^ ref_ct[k];
    end
  endtask

  task automatic load_mem();
    for (int a = 0; a < 256; a++) begin
      s_init[a]  = ref_s[a];
      ct_init[a] = ref_ct[a];
    end
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Random key and random ciphertext of length l, loaded into memory.
  task automatic prep_random(input int l);
    int klen;
    klen = $urandom_range(3, 16);
    for (int x = 0; x < 16; x++) key_b[x] = 8'($urandom);
    ksa(klen);
    ref_ct[0] = 8'(l);
    for (int x = 1; x < 256; x++) ref_ct[x] = 8'($urandom);
    load_mem();
  endtask

  task automatic wait_rdy(input string tag, input int l, input int start_busy);
    int busy;
    busy = start_busy;
    while (rdy !== 1'b1 && busy < 5000) begin
      tick();
      busy++;
    end
    chk({tag, "_done"}, {31'd0, rdy}, 32'd1);
    chk({tag, "_latency_bound"}, {31'd0, (busy <= 5 + 13 * l)}, 32'd1);
  endtask

  task automatic run_dut(input string tag, input int l);
    cur_l = l;
    en = 1'b1;
    tick();
    en = 1'b0;
    chk({tag, "_busy"}, {31'd0, rdy}, 32'd0);
    wait_rdy(tag, l, 1);
  endtask

  task automatic check_pt(input string tag, input int l);
    for (int k = 0; k <= l; k++)
      chk($sformatf("%s_pt%0d", tag, k), {24'd0, pt_mem[k]}, {24'd0, ref_pt[k]});
  endtask

  task automatic check_s(input string tag);
    for (int x = 0; x < 256; x++)
      chk($sformatf("%s_s%0d", tag, x), {24'd0, s_mem[x]}, {24'd0, ref_s[x]});
  endtask

  logic [7:0] kv_ct[10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] kv_pt[10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

  initial begin
    int l;
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    cur_l = 0;
    pt_wr_cnt = 0;
    s_wr_cnt  = 0;
    for (int x = 0; x < 256; x++) begin
      ref_s[x] = '0; ref_ct[x] = '0; ref_pt[x] = '0;
    end
    repeat (3) tick();

    // Reset state
    chk("rst_rdy", {31'd0, rdy}, 32'd1);
    chk("rst_s_wren", {31'd0, s_wren}, 32'd0);
    chk("rst_pt_wren", {31'd0, pt_wren}, 32'd0);
    chk("rst_s_addr", {24'd0, s_addr}, 32'd0);
    chk("rst_ct_addr", {24'd0, ct_addr}, 32'd0);
    chk("rst_pt_addr", {24'd0, pt_addr}, 32'd0);
    chk("rst_s_wrdata", {24'd0, s_wrdata}, 32'd0);
    chk("rst_pt_wrdata", {24'd0, pt_wrdata}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rdy", {31'd0, rdy}, 32'd1);
    mon_on = 1'b1;

    // Known vector: key "Key", ciphertext of "Plaintext"
    key_b[0] = 8'h4B; key_b[1] = 8'h65; key_b[2] = 8'h79;
    ksa(3);
    for (int x = 0; x < 256; x++) ref_ct[x] = '0;
    for (int x = 0; x < 10; x++) ref_ct[x] = kv_ct[x];
    load_mem();
    model_run(9);
    run_dut("known", 9);
    for (int k = 0; k < 10; k++)
      chk($sformatf("known_pt%0d", k), {24'd0, pt_mem[k]}, {24'd0, kv_pt[k]});
    check_s("known");

    // Identity S, one byte: i=j=1 self-swap, pad = S[2]
    for (int x = 0; x < 256; x++) ref_s[x] = 8'(x);
    ref_ct[0] = 8'h01; ref_ct[1] = 8'hFF;
    load_mem();
    run_dut("ident", 1);
    chk("ident_pt0", {24'd0, pt_mem[0]}, 32'h01);
    chk("ident_pt1", {24'd0, pt_mem[1]}, 32'hFD);
    for (int x = 0; x < 256; x++)
      chk($sformatf("ident_s%0d", x), {24'd0, s_mem[x]}, x);

    // Zero-length message
    prep_random(0);
    model_run(0);
    pt_wr_cnt = 0; s_wr_cnt = 0;
    run_dut("len0", 0);
    chk("len0_pt_writes", pt_wr_cnt, 32'd1);
    chk("len0_s_writes", s_wr_cnt, 32'd0);
    chk("len0_pt0", {24'd0, pt_mem[0]}, 32'd0);
    chk("len0_pt1_untouched", {24'd0, pt_mem[1]}, 32'd0);

    // Random short messages
    for (int r = 0; r < 3; r++) begin
      l = $urandom_range(1, 40);
      prep_random(l);
      model_run(l);
      pt_wr_cnt = 0; s_wr_cnt = 0;
      run_dut($sformatf("rand%0d", r), l);
      chk($sformatf("rand%0d_pt_writes", r), pt_wr_cnt, l + 1);
      chk($sformatf("rand%0d_s_writes", r), s_wr_cnt, 2 * l);
      check_pt($sformatf("rand%0d", r), l);
      check_s($sformatf("rand%0d", r));
    end

    // Maximum length
    prep_random(255);
    model_run(255);
    run_dut("len255", 255);
    check_pt("len255", 255);
    check_s("len255");

    // en held high: the next run starts only once rdy has returned
    prep_random(5);
    model_run(5);
    run_dut("hold1", 5);
    check_pt("hold1", 5);
    en = 1'b1;
    tick();
    chk("hold_restart_busy", {31'd0, rdy}, 32'd0);
    tick();
    chk("hold_still_busy", {31'd0, rdy}, 32'd0);
    model_run(5);
    wait_rdy("hold2", 5, 2);
    check_pt("hold2", 5);
    check_s("hold2");
    en = 1'b0;
    tick();
    chk("hold_idle_after_release", {31'd0, rdy}, 32'd1);

    // Reset in the middle of byte 3
    prep_random(10);
    cur_l = 10;
    pt_wr_cnt = 0; s_wr_cnt = 0;
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int c = 0; c < 2000 && pt_wr_cnt < 3; c++) tick();
    chk("midrst_reached_byte3", pt_wr_cnt, 32'd3);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_rdy", {31'd0, rdy}, 32'd1);
    chk("midrst_s_wren", {31'd0, s_wren}, 32'd0);
    chk("midrst_pt_wren", {31'd0, pt_wren}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("midrst_no_more_pt_writes", pt_wr_cnt, 32'd3);
    chk("midrst_no_more_s_writes", s_wr_cnt, 32'd4);
    chk("midrst_pt3_untouched", {24'd0, pt_mem[3]}, 32'd0);
    chk("midrst_idle", {31'd0, rdy}, 32'd1);

    // Reload and run cleanly after the abort
    prep_random(12);
    model_run(12);
    run_dut("after_rst", 12);
    check_pt("after_rst", 12);
    check_s("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rc4_prga.md
Name: rc4_prga

Overview:
- Pseudo-random generation and decrypt stage of the RC4 datapath. Runs after key scheduling has left the permuted S array in the 256x8 S memory.
- Walks the S array to generate keystream bytes and XORs each with a length-prefixed ciphertext buffer. Writes the length-prefixed plaintext into the plaintext memory.
- Modifies S in place (swaps) and raises rdy when the whole message is done.

Parameters:
- none (S size fixed at 256, byte width fixed at 8)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  start request, sampled only while rdy=1
- rdy  out  1  1 = idle and able to accept en
- s_addr  out  8  S memory address
- s_rddata  in  8  S memory read data
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- ct_addr  out  8  ciphertext memory address (read-only memory)
- ct_rddata  in  8  ciphertext memory read data
- pt_addr  out  8  plaintext memory address
- pt_wrdata  out  8  plaintext memory write data
- pt_wren  out  1  plaintext memory write enable

Behaviour:
- Reset: clk, clock; rst_n, synchronous, active-low.
- Reset values: FSM goes to IDLE; i, j and byte index k go to 0; all address, wrdata and wren outputs go to 0.
- rdy is 1 exactly when the FSM is in IDLE, including the first cycle after reset. Reset mid-operation aborts immediately, with no further writes.
- All outputs are registered.
- Memory timing: all memories are synchronous-read. Read data for the address driven in cycle n is valid in cycle n+1. The FSM waits one cycle before consuming any rddata. A write happens on the edge at the end of a cycle with wren=1.
- At most one of s_wren and pt_wren is high per cycle, and each is high for a single cycle per write.
- Handshake:
  - en=1 while rdy=1 starts a run; rdy=0 from the next cycle.
  - en is ignored while busy.
  - At the end of a run the FSM returns to IDLE and rdy=1.
- Algorithm (all arithmetic mod 256, 8-bit wrap):
  - L = ct[0]; write pt[0] = L.
  - For k = 1..L: i = i+1; si = S[i]; j = j+si; sj = S[j]; S[i] = sj; S[j] = si; pad = S[si+sj]; pt[k] = pad XOR ct[k].
- State sequence:
  - IDLE → RD_LEN (ct_addr=0) → WAIT_LEN → WR_LEN (pt_addr=0, pt_wrdata=L, latch L).
  - NEXT: if k == L go to IDLE; else k++, i++, drive s_addr=i.
  - WAIT_SI → CALC_J (latch si, j += si) → RD_SJ (s_addr=j) → WAIT_SJ.
  - WR_I (latch sj, s_addr=i, s_wrdata=sj, s_wren=1) → WR_J (s_addr=j, s_wrdata=si, s_wren=1, ct_addr=k).
  - RD_PAD (s_addr=si+sj, latch ct byte) → WAIT_PAD → WR_PT (pt_addr=k, pt_wrdata=s_rddata XOR ct byte, pt_wren=1) → NEXT.
- The pad read is issued only after both swap writes complete.
- i==j is legal: both writes store the same value and the pad address is 2*si.
- L=0: only pt[0]=0 is written, then the FSM returns to IDLE.
- L=255: k and i reach 255 with no overflow. The k==L compare happens before the increment, so k never wraps.
- j starts at 0 every run. i and j are not retained between runs.
- Latency: 4 cycles of header plus a fixed number of cycles per byte. The per-byte count is at most 13, and the total is at most 4 + 13L + 1 cycles from en to rdy.
- No memory write ever targets pt addresses above L.

Test Plan:
- Known vector: S = KSA(key 0x4B6579); ct = {09, BB F3 16 E8 D9 40 AF 0A D3} → pt = {09, 50 6C 61 69 6E 74 65 78 74} ("Plaintext"); rdy returns to 1.
- Identity S (S[x]=x), ct = {01, FF} → i=j=1 self-swap, pad=S[2]=02, pt = {01, FD}; S unchanged except as the reference model dictates.
- ct[0]=00 → exactly one pt write (addr 0, data 00); no s_wren pulses; rdy=1 within 6 cycles.
- L=255 with random ct and KSA S → all 256 pt bytes match the software model; j wraps multiple times; final S matches the model.
- Hold en=1 throughout a run → the second run starts only after rdy=1. Assert rst_n=0 during byte 3 → next cycle rdy=1 with all wren=0. Then reload S/ct and pulse en → correct pt.
- Protocol checker every run: s_wren and pt_wren are never high together; rdata is consumed only one cycle after its address; no writes occur while rdy=1.
